// File: rtl/bf16_pkg.sv
// bf16_pkg: shared types and constants for the bf16 accumulate stage.
//   bf16_t        - packed bf16 word {sign, exp[7:0], frac[6:0]}
//   prod_entry_t  - one product FIFO entry {prod, last, ovf, unf, inv}
//   acc_state_t   - accumulator sequencer states
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef struct packed {
    bf16_t prod;
    logic  last;
    logic  ovf;
    logic  unf;
    logic  inv;
  } prod_entry_t;

  localparam int          BF16_BIAS = 127;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND
  } acc_state_t;

endpackage

// File: rtl/bf16_prod_fifo.sv
// bf16_prod_fifo: small synchronous FIFO in front of the accumulator.
//   clk, RST        - clock, synchronous active-high reset
//   flush           - empties the FIFO; a push in the same cycle lands in the
//                     emptied FIFO
//   push, wdata     - write request; accepted when not full or when a pop
//                     happens in the same cycle
//   pop, rdata      - rdata shows the head entry; pop advances it
//   full, empty     - occupancy status
module bf16_prod_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (flush && push)  mem[0]      <= wdata;
    else if (do_push)   mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bf16_acc_stage.sv
// bf16_acc_stage: accumulates bf16 products into a running sum using a
// four-state align/add/normalize/round sequence fed from a product FIFO.
//   clk, RST                     - clock, synchronous active-high reset
//   prod_in, prod_valid          - product word and its one-cycle strobe
//   prod_last                    - product closes the current accumulation
//   prod_ovf/prod_unf/prod_inv   - multiplier flags for the product
//   clear                        - flush FIFO, accumulator and in-flight add
//   acc_out, acc_valid           - final sum (held) and its one-cycle strobe
//   acc_ovf/acc_unf/acc_nan      - sticky flags for the reported sum
//   busy                         - sequencer active or FIFO non-empty
//   drop_err                     - sticky, a product was lost to a full FIFO
module bf16_acc_stage
  import bf16_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] prod_in,
  input  logic        prod_valid,
  input  logic        prod_last,
  input  logic        prod_ovf,
  input  logic        prod_unf,
  input  logic        prod_inv,
  input  logic        clear,
  output logic [15:0] acc_out,
  output logic        acc_valid,
  output logic        acc_ovf,
  output logic        acc_unf,
  output logic        acc_nan,
  output logic        busy,
  output logic        drop_err
);

  acc_state_t  state;
  logic [15:0] acc_q;
  logic        st_ovf, st_unf, st_nan;

  prod_entry_t fifo_wdata, fifo_rdata, ent_p0;
  logic        fifo_full, fifo_empty, pop, drop;

  assign fifo_wdata = {prod_in, prod_last, prod_ovf, prod_unf, prod_inv};
  assign pop  = (state == ST_IDLE || state == ST_ROUND) && !fifo_empty && !clear;
  assign drop = prod_valid && fifo_full && !pop && !clear;
  assign busy = (state != ST_IDLE) || !fifo_empty;

  bf16_prod_fifo #(
    .DATA_W ($bits(prod_entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .flush (clear),
    .push  (prod_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd0;
    for (int i = 0; i <= 10; i++) if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  // m holds {frac[6:0], G, R, S}; returns {ovf, bf16 result}.
  function automatic logic [16:0] round_ne(input logic sign,
                                           input logic signed [9:0] e,
                                           input logic [9:0] m);
    logic             inc;
    logic [7:0]       f;
    logic signed [9:0] e_r;
    inc = m[2] & (m[1] | m[0] | m[3]);
    f   = {1'b0, m[9:3]} + {7'd0, inc};
    // A carry out of the fraction means 1.111.. rounded up to 10.000..
    e_r = f[7] ? e + 10'sd1 : e;
    if (e_r >= 10'sd255) round_ne = {1'b1, sign, 8'hFF, 7'h00};
    else                 round_ne = {1'b0, sign, e_r[7:0], f[6:0]};
  endfunction

  // ---- ALIGN: unpack, resolve specials, order by magnitude, shift ----
  bf16_t       a_op, p_op;
  logic        a_zero, p_zero, a_inf, p_inf, a_nan, p_nan;
  logic [7:0]  a_sig, p_sig, big_sig, sml_sig, big_exp, sml_exp, exp_diff;
  logic        big_sign, al_sub, al_spec, al_nan;
  logic [15:0] al_val;
  logic [10:0] sml_ext, sml_al;

  always_comb begin
    a_op   = acc_q;
    p_op   = ent_p0.prod;
    a_zero = (a_op.exp == 8'h00);
    p_zero = (p_op.exp == 8'h00);
    a_inf  = (a_op.exp == 8'hFF) && (a_op.frac == 7'h00);
    p_inf  = (p_op.exp == 8'hFF) && (p_op.frac == 7'h00);
    a_nan  = (a_op.exp == 8'hFF) && (a_op.frac != 7'h00);
    p_nan  = (p_op.exp == 8'hFF) && (p_op.frac != 7'h00);
    a_sig  = a_zero ? 8'h00 : {1'b1, a_op.frac};
    p_sig  = p_zero ? 8'h00 : {1'b1, p_op.frac};
    al_sub = a_op.sign ^ p_op.sign;

    if ({p_op.exp, p_sig} > {a_op.exp, a_sig}) begin
      big_sign = p_op.sign; big_exp = p_op.exp; big_sig = p_sig;
      sml_exp  = a_op.exp;  sml_sig = a_sig;
    end else begin
      big_sign = a_op.sign; big_exp = a_op.exp; big_sig = a_sig;
      sml_exp  = p_op.exp;  sml_sig = p_sig;
    end

    exp_diff = big_exp - sml_exp;
    sml_ext  = {sml_sig, 3'b000};
    if (exp_diff >= 8'd11) begin
      sml_al = {10'd0, |sml_sig};
    end else begin
      sml_al    = sml_ext >> exp_diff;
      sml_al[0] = sml_al[0] | (|(sml_ext & ~(11'h7FF << exp_diff)));
    end

    // Specials bypass the adder; acc_q is never a denormal, so returning it
    // for x + 0 is safe.
    al_spec = 1'b1;
    al_nan  = 1'b0;
    al_val  = acc_q;
    if (a_nan || p_nan || ent_p0.inv) begin
      al_val = BF16_QNAN; al_nan = 1'b1;
    end else if (a_inf && p_inf && al_sub) begin
      al_val = BF16_QNAN; al_nan = 1'b1;
    end else if (a_inf) begin
      al_val = acc_q;
    end else if (p_inf) begin
      al_val = BF16_PINF | {p_op.sign, 15'd0};
    end else if (p_zero) begin
      al_val = acc_q;
    end else if (a_zero) begin
      al_val = ent_p0.prod;
    end else begin
      al_spec = 1'b0;
    end
  end

  logic              spec_p1, sign_p1, sub_p1;
  logic [15:0]       spec_val_p1;
  logic signed [9:0] exp_p1;
  logic [10:0]       big_p1, sml_p1;
  logic [11:0]       sum_p2;
  logic [10:0]       m_p3;
  logic signed [9:0] e_p3;

  // ---- NORM: carry shift or leading-zero shift, underflow to +0 ----
  logic [10:0]       norm_m;
  logic signed [9:0] norm_e;
  logic              norm_zero, norm_unf;
  logic [3:0]        lz;

  always_comb begin
    norm_m    = '0;
    norm_e    = exp_p1;
    norm_zero = 1'b0;
    norm_unf  = 1'b0;
    lz        = lzc11(sum_p2[10:0]);
    if (sum_p2[11]) begin
      norm_m = {sum_p2[11:2], sum_p2[1] | sum_p2[0]};
      norm_e = exp_p1 + 10'sd1;
    end else if (sum_p2 == 12'd0) begin
      norm_zero = 1'b1;
    end else begin
      norm_m = sum_p2[10:0] << lz;
      norm_e = exp_p1 - $signed({6'd0, lz});
    end
    if (!norm_zero && norm_e <= 10'sd0) begin
      norm_zero = 1'b1;
      norm_unf  = 1'b1;
    end
    // A cleared hidden bit marks a +0 result for ROUND.
    if (norm_zero) norm_m = '0;
  end

  // ---- ROUND: nearest-even, overflow to infinity ----
  logic [16:0] rnd_word;
  logic [15:0] rnd_res;
  logic        rnd_ovf;

  always_comb begin
    rnd_word = round_ne(sign_p1, e_p3, m_p3[9:0]);
    rnd_res  = rnd_word[15:0];
    rnd_ovf  = rnd_word[16];
    if (spec_p1) begin
      rnd_res = spec_val_p1;
      rnd_ovf = 1'b0;
    end else if (!m_p3[10]) begin
      rnd_res = 16'h0000;
      rnd_ovf = 1'b0;
    end
  end

  // Datapath registers; the sequencer state qualifies them.
  always_ff @(posedge clk) begin
    if (pop) ent_p0 <= fifo_rdata;
    if (state == ST_ALIGN) begin
      spec_p1     <= al_spec;
      spec_val_p1 <= al_val;
      sign_p1     <= big_sign;
      sub_p1      <= al_sub;
      exp_p1      <= $signed({2'b00, big_exp});
      big_p1      <= {big_sig, 3'b000};
      sml_p1      <= sml_al;
    end
    // ---- ADD ----
    if (state == ST_ADD)
      sum_p2 <= sub_p1 ? ({1'b0, big_p1} - {1'b0, sml_p1})
                       : ({1'b0, big_p1} + {1'b0, sml_p1});
    if (state == ST_NORM) begin
      m_p3 <= norm_m;
      e_p3 <= norm_e;
    end
  end

  // Sequencer, accumulator and flags.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= ST_IDLE;
      acc_q     <= 16'h0000;
      st_ovf    <= 1'b0;
      st_unf    <= 1'b0;
      st_nan    <= 1'b0;
      acc_out   <= 16'h0000;
      acc_valid <= 1'b0;
      acc_ovf   <= 1'b0;
      acc_unf   <= 1'b0;
      acc_nan   <= 1'b0;
      drop_err  <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      acc_q     <= 16'h0000;
      st_ovf    <= 1'b0;
      st_unf    <= 1'b0;
      st_nan    <= 1'b0;
      acc_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (drop) drop_err <= 1'b1;
      case (state)
        ST_IDLE:  if (!fifo_empty) state <= ST_ALIGN;
        ST_ALIGN: begin
          st_ovf <= st_ovf | ent_p0.ovf;
          st_unf <= st_unf | ent_p0.unf;
          st_nan <= st_nan | al_nan;
          state  <= ST_ADD;
        end
        ST_ADD:   state <= ST_NORM;
        ST_NORM: begin
          st_unf <= st_unf | (norm_unf & ~spec_p1);
          state  <= ST_ROUND;
        end
        ST_ROUND: begin
          if (ent_p0.last) begin
            acc_out   <= rnd_res;
            acc_ovf   <= st_ovf | rnd_ovf;
            acc_unf   <= st_unf;
            acc_nan   <= st_nan;
            acc_valid <= 1'b1;
            acc_q     <= 16'h0000;
            st_ovf    <= 1'b0;
            st_unf    <= 1'b0;
            st_nan    <= 1'b0;
          end else begin
            acc_q  <= rnd_res;
            st_ovf <= st_ovf | rnd_ovf;
          end
          state <= fifo_empty ? ST_IDLE : ST_ALIGN;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_acc_stage.sv
module tb_bf16_acc_stage;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] prod_in;
  logic        prod_valid, prod_last, prod_ovf, prod_unf, prod_inv, clear;
  logic [15:0] acc_out;
  logic        acc_valid, acc_ovf, acc_unf, acc_nan, busy, drop_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_acc_stage #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .RST        (RST),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ovf   (prod_ovf),
    .prod_unf   (prod_unf),
    .prod_inv   (prod_inv),
    .clear      (clear),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ovf    (acc_ovf),
    .acc_unf    (acc_unf),
    .acc_nan    (acc_nan),
    .busy       (busy),
    .drop_err   (drop_err)
  );

  typedef struct {
    logic [15:0] a;
    logic [2:0]  fl;      // {ovf, unf, inv} sent with a
    logic [15:0] b;       // sent with last
    logic [15:0] exp_out;
    logic [2:0]  exp_fl;  // {acc_ovf, acc_unf, acc_nan}
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic last, input logic [2:0] fl);
    prod_in    = v;
    prod_valid = 1'b1;
    prod_last  = last;
    {prod_ovf, prod_unf, prod_inv} = fl;
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    {prod_ovf, prod_unf, prod_inv} = 3'b000;
  endtask

  task automatic wait_acc(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (acc_valid === 1'b1) return;
    end
    cyc = -1;
    n_cmp++;
    n_err++;
    $display("FAIL acc_valid_timeout: got none expected pulse");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL idle_timeout: got busy expected idle");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;

    tbl[0]  = '{16'h3F80, 3'b000, 16'h3F80, 16'h4000, 3'b000};
    tbl[1]  = '{16'h3FC0, 3'b000, 16'hBFC0, 16'h0000, 3'b000};
    tbl[2]  = '{16'h3F81, 3'b000, 16'h3B80, 16'h3F82, 3'b000};
    tbl[3]  = '{16'h3F80, 3'b000, 16'h3B80, 16'h3F80, 3'b000};
    tbl[4]  = '{16'h7F7F, 3'b000, 16'h7F7F, 16'h7F80, 3'b100};
    tbl[5]  = '{16'h7F80, 3'b000, 16'hFF80, 16'h7FC0, 3'b001};
    tbl[6]  = '{16'h4040, 3'b000, 16'hBF80, 16'h4000, 3'b000};
    tbl[7]  = '{16'h0081, 3'b000, 16'h8080, 16'h0000, 3'b010};
    tbl[8]  = '{16'h3F80, 3'b001, 16'h3F80, 16'h7FC0, 3'b001};
    tbl[9]  = '{16'h3F80, 3'b100, 16'h3F80, 16'h4000, 3'b100};
    tbl[10] = '{16'h3F80, 3'b000, 16'h0000, 16'h3F80, 3'b000};

    RST = 1'b1; clear = 1'b0; prod_in = 16'h0; prod_valid = 1'b0;
    prod_last = 1'b0; prod_ovf = 1'b0; prod_unf = 1'b0; prod_inv = 1'b0;
    tick(); tick();
    chk("rst_acc_out", acc_out, 16'h0000);
    chk("rst_ctrl", {acc_valid, acc_ovf, acc_unf, acc_nan, busy, drop_err}, 6'b0);
    RST = 1'b0;
    tick();

    // Vector table: a, then b+last once idle; latency 6 cycles from b's pulse.
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].a, 1'b0, tbl[i].fl);
      wait_idle();
      send(tbl[i].b, 1'b1, 3'b000);
      wait_acc(cyc);
      chk($sformatf("v%0d_lat", i), cyc + 1, 6);
      chk($sformatf("v%0d_out", i), acc_out, tbl[i].exp_out);
      chk($sformatf("v%0d_flags", i), {acc_ovf, acc_unf, acc_nan}, tbl[i].exp_fl);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      tick();
      chk($sformatf("v%0d_pulse", i), acc_valid, 1'b0);
      wait_idle();
    end

    // Six back-to-back products, last on the sixth: all absorbed.
    for (int i = 0; i < 6; i++) begin
      prod_in = 16'h3F80; prod_valid = 1'b1; prod_last = (i == 5);
      tick();
    end
    prod_valid = 1'b0; prod_last = 1'b0;
    chk("burst6_drop", drop_err, 1'b0);
    wait_acc(cyc);
    chk("burst6_out", acc_out, 16'h40C0);
    chk("burst6_flags", {acc_ovf, acc_unf, acc_nan}, 3'b000);
    wait_idle();

    // Seven back-to-back: the seventh is dropped.
    for (int i = 0; i < 7; i++) begin
      prod_in = 16'h3F80; prod_valid = 1'b1; prod_last = 1'b0;
      tick();
      if (i == 5) chk("burst7_drop6", drop_err, 1'b0);
    end
    prod_valid = 1'b0;
    chk("burst7_drop7", drop_err, 1'b1);
    wait_idle();
    chk("burst7_drop_held", drop_err, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_drop", drop_err, 1'b0);
    chk("clear_busy", busy, 1'b0);
    chk("clear_keeps_out", acc_out, 16'h40C0);

    // Clear during ADD aborts without a result.
    send(16'h3F80, 1'b0, 3'b000);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (acc_valid === 1'b1) seen++;
      tick();
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_keeps_out", acc_out, 16'h40C0);
    send(16'h4000, 1'b1, 3'b000);
    wait_acc(cyc);
    chk("after_abort_out", acc_out, 16'h4000);

    // Product arriving with clear starts the new accumulation.
    wait_idle();
    send(16'h3F80, 1'b0, 3'b000);
    wait_idle();
    prod_in = 16'h4040; prod_valid = 1'b1; prod_last = 1'b1; clear = 1'b1;
    tick();
    prod_valid = 1'b0; prod_last = 1'b0; clear = 1'b0;
    wait_acc(cyc);
    chk("clear_push_out", acc_out, 16'h4040);
    wait_idle();

    // Reset during NORM.
    send(16'h3F80, 1'b0, 3'b000);
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_out", acc_out, 16'h0000);
    chk("midrst_ctrl", {acc_valid, acc_ovf, acc_unf, acc_nan, busy, drop_err}, 6'b0);
    send(16'h3F80, 1'b1, 3'b000);
    wait_acc(cyc);
    chk("after_rst_out", acc_out, 16'h3F80);
    chk("after_rst_lat", cyc + 1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bf16_acc_stage.md
# bf16_acc_stage

Downstream stage of the bf16 multiplier in the systolic-array utility datapath. Consumes each completed product (16-bit result, one-cycle valid pulse, overflow/underflow/invalid flags) and accumulates it into a running bf16 sum using a multi-cycle align/add/normalize/round sequence. A small input FIFO absorbs product bursts, because the multiplier cannot be back-pressured. On a product tagged `last`, the stage emits the final sum and resets the accumulator.

## Interface
- `FIFO_DEPTH`, default 4: product FIFO entries (power of 2, ≥2).
- `clk  in  1`: the single clock.
- `RST  in  1`: synchronous, active-high reset.
- `prod_in  in  16`: bf16 product from the multiplier.
- `prod_valid  in  1`: one-cycle pulse; `prod_in` and flags are valid.
- `prod_last  in  1`: this product ends the current accumulation.
- `prod_ovf`, `prod_unf`, `prod_inv`  in  1 each: multiplier flags accompanying `prod_valid`.
- `clear  in  1`: synchronous flush of the FIFO, accumulator and in-flight add.
- `acc_out  out  16`: final bf16 sum; held until the next `acc_valid`.
- `acc_valid  out  1`: one-cycle pulse; `acc_out` and `acc_*` flags are valid.
- `acc_ovf`, `acc_unf`, `acc_nan`  out  1 each: sticky flags over the accumulation just reported.
- `busy  out  1`: FSM not IDLE, or FIFO not empty.
- `drop_err  out  1`: sticky; a product was lost to a full FIFO.

## Operation
- **FIFO entry**: {prod_in, last, ovf, unf, inv}.
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the product is dropped and `drop_err` is set.
- **FSM**: IDLE → ALIGN → ADD → NORM → ROUND.
  - IDLE: pops when the FIFO is non-empty and goes to ALIGN; otherwise stays.
  - ROUND: pops the next entry and goes to ALIGN if the FIFO is non-empty; otherwise goes to IDLE.
- **ALIGN**
  - Unpack the accumulator A and product P into sign, 8-bit exponent, and 8-bit significand with hidden bit (exp==0 → value 0; denormals are flushed).
  - Swap so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into an 11-bit field (8 + G, R, S). Shifted-out bits OR into S. A difference ≥11 leaves only S.
- **ADD**
  - Signs equal: add, producing a 12-bit result with carry.
  - Signs differ: subtract smaller from larger; the result takes the larger operand's sign.
- **NORM**
  - Carry out: shift right 1 (LSB ORs into S), exponent +1.
  - Otherwise: left-shift by the leading-zero count (≤10), exponent −lzc.
  - Exponent ≤0 → result +0, set `unf`.
- **ROUND**: round-to-nearest-even.
  - Increment when G && (R || S || lsb).
  - A mantissa carry increments the exponent.
  - Exponent ≥255 → ±inf (`0x7F80`/`0xFF80`), set `ovf`.
  - Write the result to the accumulator.
- **Specials**, resolved in ALIGN and passed through:
  - Any NaN operand, or `prod_inv` set → `0x7FC0`, `nan`.
  - inf + −inf → `0x7FC0`, `nan`.
  - inf + finite → inf.
  - x + 0 → x.
  - Exact-zero difference → +0.
- **Flags**: sticky flags OR in `prod_ovf`/`prod_unf` per popped entry plus adder events.
- **Last entry**: when an entry with `last`=1 completes ROUND:
  - `acc_out` ← result; `acc_*` ← sticky flags; `acc_valid`=1 for one cycle.
  - Accumulator ← +0; sticky flags cleared.
- **Clear**
  - The FSM goes to IDLE, the FIFO empties, the accumulator becomes +0, and sticky flags and `drop_err` clear.
  - No `acc_valid` is generated for an aborted add.
  - A `prod_valid` in the same cycle as `clear` is enqueued into the emptied FIFO and belongs to the new accumulation.
  - `clear` does not affect `acc_out`.
- **Reset**: all outputs 0, accumulator `0x0000`, FSM IDLE, FIFO empty.

## Timing
- `prod_valid` in cycle 0 with the FSM idle: pop at the end of cycle 1; ALIGN c2, ADD c3, NORM c4, ROUND c5; `acc_valid` high in c6.
- Sustained throughput: one product per 4 cycles.
- With `FIFO_DEPTH`=4 and the FSM idle, 6 back-to-back pulses are absorbed. A 7th consecutive pulse is dropped.
- `busy` deasserts the cycle after ROUND when the FIFO is empty.
- `RST` takes priority over `clear`, and `clear` over all other activity.

## Structure
- `bf16_pkg`:
  - `bf16_t` packed struct {sign, exp[7:0], frac[6:0]}.
  - Constants `BF16_BIAS`=127, `BF16_QNAN`=`16'h7FC0`, `BF16_PINF`=`16'h7F80`.
  - FSM state enum `acc_state_t`.
- One sub-module, `bf16_prod_fifo`: synchronous FIFO with parameterized width and depth, `push`/`pop`/`full`/`empty`, and a synchronous active-high flush.

## Test plan
- `0x3F80` then `0x3F80`+last → `acc_out`=`0x4000`. `acc_valid` arrives 6 cycles after the last product's pulse when the FSM is idle.
- `0x3FC0`, `0xBFC0`+last → `0x0000`, no flags. `0x3F81`, `0x3B80`+last → `0x3F82` (tie rounds up to even). `0x3F80`, `0x3B80`+last → `0x3F80`.
- `0x7F7F`, `0x7F7F`+last → `0x7F80`, `acc_ovf`=1. `0x7F80`, `0xFF80`+last → `0x7FC0`, `acc_nan`=1.
- 6 back-to-back pulses of `0x3F80`, last on the 6th → `0x40C0`, `drop_err`=0. Then 7 back-to-back pulses → `drop_err`=1.
- `0x3F80` issued, `clear` during ADD → no `acc_valid`, `busy`=0 next cycle. Then `0x4000`+last → `0x4000`.
- `RST` asserted mid-NORM → all outputs 0 next cycle. Subsequent `0x3F80`+last → `0x3F80`.
